bip_control_unit: RTL
=====================

Name: bip_control_unit

Overview:
Instruction fetch/decode/sequencing stage for the accumulator processor. It sits directly upstream of the datapath.
- Owns the program counter and the instruction register.
- Drives the program-memory address.
- Issues data-RAM read/write strobes.
- Produces every datapath control: mux selects, accumulator enable, add/sub select, operand.
- Runs a 3-state fetch/decode/execute FSM plus a sticky HALT state.

Parameters:
NB_INSTRUCTION, 16, instruction word width
NB_OPCODE, 5, opcode field width (instruction MSBs)
NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand field width (instruction LSBs)
NB_ADDR, 11, program/data address width
NB_SELECTOR_A, 2, datapath mux-A select width

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset  in  1  synchronous, active-low reset
i_enable  in  1  1 = advance FSM; 0 = freeze all state and outputs
i_instruction  in  NB_INSTRUCTION  program-memory read data; 1-cycle synchronous read latency from o_pc
o_pc  out  NB_ADDR  program-memory address
o_ram_addr  out  NB_ADDR  data-RAM address (operand field of IR)
o_rd_ram  out  1  data-RAM read strobe
o_wr_ram  out  1  data-RAM write strobe (data = accumulator)
o_operand  out  NB_OPERAND  operand field, to datapath sign extender
o_sel_a  out  NB_SELECTOR_A  00 ram data, 01 sign-extended operand, 10 adder result
o_sel_b  out  1  0 ram data, 1 sign-extended operand
o_enb_acc  out  1  accumulator load enable
o_operation  out  1  0 add, 1 sub
o_halt  out  1  sticky halt flag

Behaviour:
- Reset:
  - i_reset==0 at a rising edge forces state FETCH, pc=0, IR=0, all outputs 0, o_sel_a=00.
  - Reset takes priority over i_enable.
  - Reset mid-instruction, including from HALT, aborts the instruction; no strobe is emitted afterwards.
- All outputs are registered. Controls change only on clock edges.
- Opcodes (5 bits):
  - 00000 HLT
  - 00001 STO: wr_ram
  - 00010 LD: sel_a=00, enb_acc
  - 00011 LDI: sel_a=01, enb_acc
  - 00100 ADD: sel_a=10, sel_b=0, op=0, enb_acc
  - 00101 ADDI: sel_a=10, sel_b=1, op=0, enb_acc
  - 00110 SUB: sel_a=10, sel_b=0, op=1, enb_acc
  - 00111 SUBI: sel_a=10, sel_b=1, op=1, enb_acc
  - 01000..11111: NOP (no strobes, no enb_acc, pc still advances).
- FSM (only when i_enable=1):
  - FETCH: o_pc=pc held. All strobes 0. Next state is DECODE.
  - DECODE:
    - Capture i_instruction into IR.
    - Set o_operand and o_ram_addr from IR operand.
    - Assert o_rd_ram for the whole cycle for LD, ADD and SUB.
    - HLT: next state HALT and o_halt=1. Otherwise next state EXEC.
  - EXEC:
    - Drive the decoded controls for exactly one cycle: enb_acc, sel_a, sel_b, operation, wr_ram.
    - pc <= pc+1 with wrap (2^NB_ADDR-1 -> 0).
    - Next state FETCH. Strobes return to 0 in FETCH.
  - HALT: all strobes 0, pc frozen, o_halt=1 until reset.
- CPI is 3 cycles. HLT takes 2 cycles to reach HALT.
- o_rd_ram and o_wr_ram are never both 1 in the same cycle.
- o_enb_acc is never 1 outside EXEC.
- i_enable=0 in any state: state, pc, IR and outputs hold. A strobe that is active is extended for the frozen cycles.

Optional Feature:
- Macro CU_INSTR_COUNT_EN.
- Defined:
  - Adds output o_instr_count [15:0].
  - Reset 0; +1 on each EXEC cycle with i_enable=1, i.e. each retired non-HLT instruction.
  - Saturates at 16'hFFFF.
  - HLT and NOPs: NOPs count, HLT does not.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams (HLT..SUBI)
  - SEL_A_RAM/SEL_A_IMM/SEL_A_ALU encodings
  - OP_ADD/OP_SUB
  - FSM state encodings (2-bit: FETCH, DECODE, EXEC, HALT)
  - default widths
- One natural sub-module: bip_pc (NB_ADDR-wide program counter with synchronous active-low clear, increment enable, wrap).
- Decode stays inline as a combinational case feeding the output registers.

Test Plan:
- Reset then run with i_enable=1 and program LDI 5 at 0: o_pc=0; DECODE cycle o_operand=5; EXEC cycle o_sel_a=01 and o_enb_acc=1; next FETCH o_pc=1.
- ADD 0x010: DECODE o_rd_ram=1 with o_ram_addr=0x010; EXEC sel_a=10, sel_b=0, op=0, enb_acc=1; no wr_ram at any point.
- SUBI 0x7FF then STO 0x020: EXEC op=1, sel_b=1, o_operand=0x7FF; next instruction EXEC o_wr_ram=1 with o_ram_addr=0x020.
- HLT at pc=3: o_halt=1 two cycles after FETCH of pc 3; o_pc stays 3 for 20 cycles with no strobes; drive i_reset=0 for one cycle -> o_pc=0, o_halt=0.
- pc wrap and stall: preload 2047 NOPs so pc reaches 0x7FF; after its EXEC o_pc=0. Drop i_enable for 5 cycles during EXEC -> o_enb_acc held and pc unchanged until i_enable returns.
- With CU_INSTR_COUNT_EN: LDI, ADDI, NOP, HLT -> o_instr_count=3 and stays 3 in HALT.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg -- shared definitions for the accumulator processor control unit.
//   * default widths of the instruction / address / selector fields
//   * opcode encodings (HLT..SUBI; every other opcode is a NOP)
//   * datapath mux-A and add/sub encodings
//   * 2-bit FSM state encoding and the EXEC control bundle
//   * exec_ctrl(): opcode -> controls driven during EXEC
//   * reads_ram(): opcodes that need the data RAM read during DECODE
package bip_pkg;

    localparam int NB_INSTRUCTION_DEF = 16;
    localparam int NB_OPCODE_DEF      = 5;
    localparam int NB_ADDR_DEF        = 11;
    localparam int NB_SELECTOR_A_DEF  = 2;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    localparam logic [1:0] SEL_A_RAM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       operation;
        logic       enb_acc;
        logic       wr_ram;
    } exec_ctrl_t;

    function automatic exec_ctrl_t exec_ctrl(input logic [OPC_W-1:0] opc);
        exec_ctrl_t c;
        c = '0;
        case (opc)
            OPC_STO:  c.wr_ram = 1'b1;
            OPC_LD:   begin c.sel_a = SEL_A_RAM; c.enb_acc = 1'b1; end
            OPC_LDI:  begin c.sel_a = SEL_A_IMM; c.enb_acc = 1'b1; end
            OPC_ADD:  begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b0; c.operation = OP_ADD; c.enb_acc = 1'b1; end
            OPC_ADDI: begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; c.operation = OP_ADD; c.enb_acc = 1'b1; end
            OPC_SUB:  begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b0; c.operation = OP_SUB; c.enb_acc = 1'b1; end
            OPC_SUBI: begin c.sel_a = SEL_A_ALU; c.sel_b = 1'b1; c.operation = OP_SUB; c.enb_acc = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic reads_ram(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

endpackage

// File: rtl/bip_pc.sv
// bip_pc -- program counter.
//   clock : rising-edge clock
//   reset : synchronous active-low clear (wins over inc)
//   inc   : advance by one, wrapping from all-ones to zero
//   pc    : current program counter
module bip_pc #(
    parameter int NB_ADDR = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inc,
    output logic [NB_ADDR-1:0] pc
);

    always_ff @(posedge clock) begin
        if (!reset)
            pc <= '0;
        else if (inc)
            pc <= pc + NB_ADDR'(1);
    end

endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit -- fetch/decode/execute sequencer of the accumulator processor.
// Optional feature macro: CU_INSTR_COUNT_EN (adds o_instr_count, saturating 16-bit
// count of retired non-HLT instructions).
//
// Ports:
//   i_clock, i_reset (sync, active-low), i_enable (0 freezes everything)
//   i_instruction : program memory data, one cycle behind o_pc
//   o_pc          : program memory address
//   o_ram_addr, o_rd_ram, o_wr_ram : data RAM address and strobes
//   o_operand, o_sel_a, o_sel_b, o_enb_acc, o_operation : datapath controls
//   o_halt        : sticky halt flag (cleared only by reset)
//   o_instr_count : (CU_INSTR_COUNT_EN only) retired instruction count
//
// Every output is a register loaded on the edge that enters a state, so the
// outputs seen during a cycle belong to the state held in that cycle.
// The PC advances on the edge entering EXEC; the memory therefore already
// reads the next instruction during EXEC and presents it during FETCH, where
// it is captured into IR on the way to DECODE. After reset the memory needs
// one cycle with o_pc=0 (reset held two cycles, or i_enable low for the first
// cycle) before the first FETCH may advance.
//
// state  | meaning
// FETCH  | o_pc addresses the instruction, strobes 0
// DECODE | IR loaded, operand/ram_addr valid, rd_ram for LD/ADD/SUB
// EXEC   | decoded controls for one cycle, PC already incremented
// HALT   | sticky, all strobes 0, PC frozen
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int NB_INSTRUCTION = NB_INSTRUCTION_DEF,
    parameter int NB_OPCODE      = NB_OPCODE_DEF,
    parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
    parameter int NB_ADDR        = NB_ADDR_DEF,
    parameter int NB_SELECTOR_A  = NB_SELECTOR_A_DEF
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDR-1:0]        o_pc,
    output logic [NB_ADDR-1:0]        o_ram_addr,
    output logic                      o_rd_ram,
    output logic                      o_wr_ram,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [NB_SELECTOR_A-1:0]  o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_enb_acc,
    output logic                      o_operation,
    output logic                      o_halt
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [15:0]               o_instr_count
`endif
);

    state_t                    state, next_state;
    logic [NB_INSTRUCTION-1:0] ir, ir_next;
    logic                      rd_ram, rd_ram_next;
    logic                      halt, halt_next;
    exec_ctrl_t                ctrl, ctrl_next;
    logic [OPC_W-1:0]          fetch_opc, ir_opc;
    logic                      pc_inc;

    assign fetch_opc = OPC_W'(i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE]);
    assign ir_opc    = OPC_W'(ir[NB_INSTRUCTION-1 -: NB_OPCODE]);

    // Only the DECODE->EXEC transition retires an instruction.
    assign pc_inc = i_enable && (state == ST_DECODE) && (ir_opc != OPC_HLT);

    bip_pc #(.NB_ADDR(NB_ADDR)) u_pc (
        .clock (i_clock),
        .reset (i_reset),
        .inc   (pc_inc),
        .pc    (o_pc)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            state <= ST_FETCH;
        else if (i_enable)
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        ir_next     = ir;
        rd_ram_next = 1'b0;
        halt_next   = 1'b0;
        ctrl_next   = '0;
        case (state)
            ST_FETCH: begin
                next_state  = ST_DECODE;
                ir_next     = i_instruction;
                rd_ram_next = reads_ram(fetch_opc);
                halt_next   = (fetch_opc == OPC_HLT);
            end
            ST_DECODE: begin
                if (ir_opc == OPC_HLT) begin
                    next_state = ST_HALT;
                    halt_next  = 1'b1;
                end else begin
                    next_state = ST_EXEC;
                    ctrl_next  = exec_ctrl(ir_opc);
                end
            end
            ST_EXEC: next_state = ST_FETCH;
            ST_HALT: halt_next  = 1'b1;
            default: next_state = ST_FETCH;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            ir     <= '0;
            rd_ram <= 1'b0;
            halt   <= 1'b0;
            ctrl   <= '0;
        end else if (i_enable) begin
            ir     <= ir_next;
            rd_ram <= rd_ram_next;
            halt   <= halt_next;
            ctrl   <= ctrl_next;
        end
    end

    assign o_operand   = ir[NB_OPERAND-1:0];
    assign o_ram_addr  = NB_ADDR'(ir[NB_OPERAND-1:0]);
    assign o_rd_ram    = rd_ram;
    assign o_wr_ram    = ctrl.wr_ram;
    assign o_sel_a     = NB_SELECTOR_A'(ctrl.sel_a);
    assign o_sel_b     = ctrl.sel_b;
    assign o_enb_acc   = ctrl.enb_acc;
    assign o_operation = ctrl.operation;
    assign o_halt      = halt;

`ifdef CU_INSTR_COUNT_EN
    logic [15:0] instr_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset)
            instr_count <= '0;
        else if (pc_inc && (instr_count != 16'hFFFF))
            instr_count <= instr_count + 16'd1;
    end

    assign o_instr_count = instr_count;
`endif

endmodule
